// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared constants for the cache line fill controller: default geometry and
// the state encoding used by the top-level FSM.
package cache_line_fill_ctrl_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_LINE_WORDS = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/cache_line_fill_ctrl_fill_counter.sv
// Word counter with synchronous clear and increment; clear wins over increment.
module fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Cache miss handler: optional dirty-victim write-back, then a pipelined line
// fill from memory into the data array, finished by a single tag write.
module cache_line_fill_ctrl
    import cache_line_fill_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int WB_EN      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_address,
    input  logic [DATA_W-1:0] victim_data,
    output logic [ADDR_W-1:0] cache_rd_address,
    output logic              memory_enable,
    output logic              memory_wr,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_data_out,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              fsm_busy,
    output logic              fill_done
);

    localparam int STEP  = DATA_W / 8;
    localparam int SH    = $clog2(STEP);
    localparam int OFF_W = $clog2(LINE_WORDS * STEP);
    localparam int CNT_W = $clog2(LINE_WORDS) + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] miss_base_q, miss_base_d;
    logic [ADDR_W-1:0] victim_base_q, victim_base_d;
    logic [CNT_W-1:0]  wb_cnt, iss_cnt, rcv_cnt;
    logic              cnt_clr, wb_inc, iss_inc, rcv_inc;
    logic [ADDR_W-1:0] wb_addr;

    // Only the offset field moves; the line-base bits come straight from base.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        logic [OFF_W-1:0] off;
        off = OFF_W'(idx) << SH;
        return (base & ~OFF_MASK) | ADDR_W'(off);
    endfunction

    fill_counter #(.W(CNT_W)) u_wb_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(wb_inc), .cnt(wb_cnt)
    );
    fill_counter #(.W(CNT_W)) u_iss_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(iss_inc), .cnt(iss_cnt)
    );
    fill_counter #(.W(CNT_W)) u_rcv_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(rcv_inc), .cnt(rcv_cnt)
    );

    assign wb_addr = word_addr(victim_base_q, wb_cnt);

    always_comb begin
        state_d          = state_q;
        miss_base_d      = miss_base_q;
        victim_base_d    = victim_base_q;
        cnt_clr          = 1'b0;
        wb_inc           = 1'b0;
        iss_inc          = 1'b0;
        rcv_inc          = 1'b0;
        cache_rd_address = '0;
        memory_enable    = 1'b0;
        memory_wr        = 1'b0;
        memory_address   = '0;
        memory_data_out  = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        write_address    = '0;
        write_data       = '0;
        fsm_busy         = 1'b0;
        fill_done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    miss_base_d   = miss_address & ~OFF_MASK;
                    victim_base_d = victim_address & ~OFF_MASK;
                    cnt_clr       = 1'b1;
                    state_d       = ((WB_EN != 0) && victim_dirty) ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                fsm_busy         = 1'b1;
                memory_enable    = 1'b1;
                memory_wr        = 1'b1;
                cache_rd_address = wb_addr;
                memory_address   = wb_addr;
                memory_data_out  = victim_data;
                wb_inc           = 1'b1;
                if (wb_cnt == CNT_W'(LINE_WORDS - 1)) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                fsm_busy = 1'b1;
                // Issue and receive run concurrently; responses return in order.
                if (iss_cnt < CNT_W'(LINE_WORDS)) begin
                    memory_enable  = 1'b1;
                    memory_address = word_addr(miss_base_q, iss_cnt);
                    iss_inc        = 1'b1;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    write_address    = word_addr(miss_base_q, rcv_cnt);
                    write_data       = memory_data;
                    rcv_inc          = 1'b1;
                    if (rcv_cnt == CNT_W'(LINE_WORDS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                fill_done       = 1'b1;
                write_address   = miss_base_q;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            miss_base_q   <= '0;
            victim_base_q <= '0;
        end else begin
            state_q       <= state_d;
            miss_base_q   <= miss_base_d;
            victim_base_q <= victim_base_d;
        end
    end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench for cache_line_fill_ctrl: three configurations driven side by side
// (defaults, WB_EN=0, LINE_WORDS=4) against a transaction-level reference.
module tb_cache_line_fill_ctrl;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        victim_dirty = 1'b0;
    logic [15:0] victim_address = '0;

    logic [15:0] vdata [NI];
    logic [15:0] cra   [NI];
    logic [15:0] maddr [NI];
    logic [15:0] mdout [NI];
    logic [15:0] mdata [NI];
    logic [15:0] wa    [NI];
    logic [15:0] wd    [NI];
    logic        men   [NI];
    logic        mwr   [NI];
    logic        mdv   [NI];
    logic        wda   [NI];
    logic        wta   [NI];
    logic        busy  [NI];
    logic        fdone [NI];
    logic        stray [NI] = '{default: 1'b0};

    for (genvar g = 0; g < NI; g++) begin : gi
        assign vdata[g] = cra[g] ^ 16'hC3A5;
        cache_line_fill_ctrl #(
            .ADDR_W(16), .DATA_W(16),
            .LINE_WORDS((g == 2) ? 4 : 8),
            .WB_EN((g == 1) ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .miss_detected(miss_detected), .miss_address(miss_address),
            .victim_dirty(victim_dirty), .victim_address(victim_address),
            .victim_data(vdata[g]), .cache_rd_address(cra[g]),
            .memory_enable(men[g]), .memory_wr(mwr[g]),
            .memory_address(maddr[g]), .memory_data_out(mdout[g]),
            .memory_data(mdata[g]), .memory_data_valid(mdv[g]),
            .write_data_array(wda[g]), .write_tag_array(wta[g]),
            .write_address(wa[g]), .write_data(wd[g]),
            .fsm_busy(busy[g]), .fill_done(fdone[g])
        );
    end

    function automatic int lw_of(input int g);
        return (g == 2) ? 4 : 8;
    endfunction
    function automatic int lat_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 3 : 5);
    endfunction
    function automatic logic [15:0] mask_of(input int g);
        return (g == 2) ? 16'hFFF8 : 16'hFFF0;
    endfunction

    // Memory model: each read returns lat_of(g) cycles after issue, in order.
    int          cyc = 0;
    logic        ring_v [NI][16] = '{default: '{default: 1'b0}};
    logic [15:0] ring_d [NI][16] = '{default: '{default: 16'h0}};

    always @(posedge clk) begin
        cyc++;
        #2;
        for (int g = 0; g < NI; g++) begin
            mdv[g]   = ring_v[g][cyc % 16] | stray[g];
            mdata[g] = ring_v[g][cyc % 16] ? ring_d[g][cyc % 16] : 16'($urandom);
        end
    end

    int checks = 0;
    int failures = 0;

    bit          m_act [NI] = '{default: 1'b0};
    int          m_wb  [NI] = '{default: 0};
    int          m_nwb [NI] = '{default: 0};
    int          m_iss [NI] = '{default: 0};
    int          m_rcv [NI] = '{default: 0};
    logic [15:0] m_mb  [NI] = '{default: 16'h0};
    logic [15:0] m_vb  [NI] = '{default: 16'h0};

    int          o_nrd [NI] = '{default: 0};
    int          o_nwr [NI] = '{default: 0};
    int          o_ncw [NI] = '{default: 0};
    int          o_lastv [NI] = '{default: 0};
    logic [15:0] o_rd  [NI][8];
    logic [15:0] o_wr0 [NI] = '{default: 16'h0};

    bit          lit_en   [NI] = '{default: 1'b0};
    logic [15:0] lit_base [NI] = '{default: 16'h0};
    logic [15:0] lit_wr0  [NI] = '{default: 16'h0};
    int          lit_nwr  [NI] = '{default: 0};

    bit rst_prev = 1'b0;
    bit chk_en = 1'b0;
    bit timeout_hit = 1'b0;
    bit tmo_seen = 1'b0;

    always @(negedge clk) begin : cmp_blk
        logic        e_en, e_wr, e_wda, e_wta, e_busy, e_done;
        logic [15:0] e_addr, e_dout, e_cra, e_wa, e_wd;
        logic [85:0] act_v, exp_v;
        int          lw;
        if (rst_prev) chk_en = 1'b1;
        for (int g = 0; g < NI; g++) begin
            lw = lw_of(g);
            e_en = 0; e_wr = 0; e_wda = 0; e_wta = 0; e_busy = 0; e_done = 0;
            e_addr = '0; e_dout = '0; e_cra = '0; e_wa = '0; e_wd = '0;
            if (!m_act[g]) begin
                e_busy = miss_detected;
            end else begin
                e_busy = 1'b1;
                if (m_rcv[g] == lw) begin
                    e_wta = 1'b1; e_done = 1'b1; e_wa = m_mb[g];
                end else if (m_wb[g] < m_nwb[g]) begin
                    e_en = 1'b1; e_wr = 1'b1;
                    e_addr = m_vb[g] + 16'(2 * m_wb[g]);
                    e_cra = e_addr;
                    e_dout = e_addr ^ 16'hC3A5;
                end else begin
                    if (m_iss[g] < lw) begin
                        e_en = 1'b1;
                        e_addr = m_mb[g] + 16'(2 * m_iss[g]);
                    end
                    if (mdv[g]) begin
                        e_wda = 1'b1;
                        e_wa = m_mb[g] + 16'(2 * m_rcv[g]);
                        e_wd = mdata[g];
                    end
                end
            end
            exp_v = {e_en, e_wr, e_addr, e_dout, e_cra, e_wda, e_wta, e_wa, e_wd, e_busy, e_done};
            act_v = {men[g], mwr[g], maddr[g], mdout[g], cra[g], wda[g], wta[g], wa[g], wd[g],
                     busy[g], fdone[g]};
            if (chk_en) begin
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL cycle_outputs inst=%0d cyc=%0d got=%h want=%h", g, cyc, act_v, exp_v);
                end
                if (rst_prev && !miss_detected) begin
                    checks++;
                    if (act_v !== 86'h0) begin
                        failures++;
                        $display("FAIL reset_outputs inst=%0d got=%h want=0", g, act_v);
                    end
                end
            end

            ring_v[g][(cyc + lat_of(g)) % 16] = men[g] && !mwr[g];
            ring_d[g][(cyc + lat_of(g)) % 16] = 16'($urandom);
            if (men[g] && !mwr[g]) begin
                if (o_nrd[g] < 8) o_rd[g][o_nrd[g]] = maddr[g];
                o_nrd[g]++;
            end
            if (men[g] && mwr[g]) begin
                if (o_nwr[g] == 0) o_wr0[g] = maddr[g];
                o_nwr[g]++;
            end
            if (wda[g]) begin
                o_ncw[g]++;
                o_lastv[g] = cyc;
            end

            // Hand-computed expectations for the directed scenarios.
            if (chk_en && lit_en[g] && m_act[g] && m_rcv[g] == lw) begin
                for (int k = 0; k < lw; k++) begin
                    checks++;
                    if (o_rd[g][k] !== lit_base[g] + 16'(2 * k)) begin
                        failures++;
                        $display("FAIL read_addr inst=%0d k=%0d got=%h want=%h", g, k, o_rd[g][k],
                                 lit_base[g] + 16'(2 * k));
                    end
                end
                checks++;
                if (o_nrd[g] != lw) begin
                    failures++;
                    $display("FAIL read_count inst=%0d got=%0d want=%0d", g, o_nrd[g], lw);
                end
                checks++;
                if (o_nwr[g] != lit_nwr[g]) begin
                    failures++;
                    $display("FAIL wb_count inst=%0d got=%0d want=%0d", g, o_nwr[g], lit_nwr[g]);
                end
                if (lit_nwr[g] > 0) begin
                    checks++;
                    if (o_wr0[g] !== lit_wr0[g]) begin
                        failures++;
                        $display("FAIL wb_first_addr inst=%0d got=%h want=%h", g, o_wr0[g], lit_wr0[g]);
                    end
                end
                checks++;
                if (o_ncw[g] != lw) begin
                    failures++;
                    $display("FAIL cache_writes inst=%0d got=%0d want=%0d", g, o_ncw[g], lw);
                end
                checks++;
                if (cyc != o_lastv[g] + 1) begin
                    failures++;
                    $display("FAIL done_latency inst=%0d got=%0d want=%0d", g, cyc, o_lastv[g] + 1);
                end
            end

            if (rst) begin
                m_act[g] = 1'b0;
            end else if (!m_act[g]) begin
                if (miss_detected) begin
                    m_act[g] = 1'b1;
                    m_mb[g]  = miss_address & mask_of(g);
                    m_vb[g]  = victim_address & mask_of(g);
                    m_nwb[g] = (g != 1 && victim_dirty) ? lw : 0;
                    m_wb[g] = 0; m_iss[g] = 0; m_rcv[g] = 0;
                    o_nrd[g] = 0; o_nwr[g] = 0; o_ncw[g] = 0; o_lastv[g] = -10;
                end
            end else if (m_rcv[g] == lw) begin
                m_act[g] = 1'b0;
            end else if (m_wb[g] < m_nwb[g]) begin
                m_wb[g]++;
            end else begin
                if (m_iss[g] < lw) m_iss[g]++;
                if (mdv[g]) m_rcv[g]++;
            end
        end
        if (timeout_hit && !tmo_seen) begin
            tmo_seen = 1'b1;
            checks++;
            failures++;
            $display("FAIL idle_timeout got=busy want=idle at cyc=%0d", cyc);
        end
        rst_prev = rst;
    end

    task automatic set_lit(input int g, input logic [15:0] base, input int nwr, input logic [15:0] wr0);
        lit_en[g] = 1'b1; lit_base[g] = base; lit_nwr[g] = nwr; lit_wr0[g] = wr0;
    endtask

    task automatic clr_lit();
        for (int g = 0; g < NI; g++) lit_en[g] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 400 && (m_act[0] || m_act[1] || m_act[2])) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) timeout_hit = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [15:0] a, input logic [15:0] va, input logic dirty, input int hold);
        @(posedge clk); #1;
        miss_detected = 1'b1; miss_address = a; victim_address = va; victim_dirty = dirty;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            miss_address = 16'hFFFF;
            victim_address = 16'hAAAA;
        end
        @(posedge clk); #1;
        miss_detected = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Clean miss.
        set_lit(0, 16'h1230, 0, 16'h0); set_lit(1, 16'h1230, 0, 16'h0); set_lit(2, 16'h1230, 0, 16'h0);
        start_miss(16'h1234, 16'h5670, 1'b0, 1);
        wait_idle();

        // Dirty miss, request dropped two cycles after acceptance, stray valid during write-back.
        set_lit(0, 16'h1230, 8, 16'h5670); set_lit(1, 16'h1230, 0, 16'h0); set_lit(2, 16'h1230, 4, 16'h5670);
        @(posedge clk); #1;
        miss_detected = 1'b1; miss_address = 16'h1234; victim_address = 16'h5670; victim_dirty = 1'b1;
        @(posedge clk); #1; miss_address = 16'hBEEF;
        @(posedge clk); #1; stray[0] = 1'b1;
        @(posedge clk); #1; stray[0] = 1'b0; miss_detected = 1'b0;
        wait_idle();

        // Reset in the middle of the fill, then a fresh miss.
        clr_lit();
        start_miss(16'h1234, 16'h5670, 1'b0, 1);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        set_lit(0, 16'h2000, 0, 16'h0); set_lit(1, 16'h2000, 0, 16'h0); set_lit(2, 16'h2000, 0, 16'h0);
        start_miss(16'h2000, 16'h3000, 1'b0, 1);
        wait_idle();

        // Stray valids while idle, then an unaligned miss.
        for (int g = 0; g < NI; g++) stray[g] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) stray[g] = 1'b0;
        set_lit(0, 16'h00F0, 8, 16'h00F0); set_lit(1, 16'h00F0, 0, 16'h0); set_lit(2, 16'h00F8, 4, 16'h00F8);
        start_miss(16'h00F9, 16'h00F9, 1'b1, 1);
        wait_idle();

        clr_lit();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int g = 0; g < NI; g++) stray[g] = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                for (int g = 0; g < NI; g++) stray[g] = 1'b0;
            end
            start_miss(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(2, 20)) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                repeat (10) @(posedge clk);
            end else begin
                wait_idle();
            end
        end
        pulse_rst();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_line_fill_ctrl.md
CACHE_LINE_FILL_CTRL -- requirements
Module: cache_line_fill_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning word width; it SHALL be a multiple of 8.
REQ-003 The block SHALL have parameter LINE_WORDS, default 8, meaning words per line; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have parameter WB_EN, default 1, meaning 1 = write back a dirty victim before the fill.
REQ-005 The block SHALL have ports as follows; it uses one clock, and reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss_detected  in  1  cache miss request
- miss_address  in  ADDR_W  missing byte address
- victim_dirty  in  1  victim line is dirty
- victim_address  in  ADDR_W  victim line byte address
- victim_data  in  DATA_W  cache word at cache_rd_address (combinational)
- cache_rd_address  out  ADDR_W  victim word being read out
- memory_enable  out  1  memory request
- memory_wr  out  1  1 = write, 0 = read
- memory_address  out  ADDR_W  request address
- memory_data_out  out  DATA_W  write data
- memory_data  in  DATA_W  read return data
- memory_data_valid  in  1  read return valid; returns are in order
- write_data_array  out  1  cache data write enable
- write_tag_array  out  1  cache tag write enable
- write_address  out  ADDR_W  cache write address
- write_data  out  DATA_W  cache write data
- fsm_busy  out  1  stall request
- fill_done  out  1  one-cycle completion pulse

Function
REQ-006 Derived constants SHALL be: STEP = DATA_W/8, OFF_W = log2(LINE_WORDS*STEP), CNT_W = log2(LINE_WORDS)+1.
REQ-007 The state machine SHALL have states IDLE, WB, FILL and DONE.
REQ-008 In IDLE with miss_detected=1, the block SHALL latch the miss line base ({miss_address[ADDR_W-1:OFF_W], 0}) and the victim line base, and clear all counters.
REQ-009 From IDLE, the block SHALL go to WB if WB_EN & victim_dirty, otherwise to FILL.
REQ-010 In WB, each cycle the block SHALL drive memory_enable=1, memory_wr=1, memory_address = cache_rd_address = victim base + wb_cnt*STEP, and memory_data_out = victim_data; wb_cnt SHALL then increment.
REQ-011 After the WB write with wb_cnt = LINE_WORDS-1, the block SHALL go to FILL.
REQ-012 In FILL, while iss_cnt < LINE_WORDS, the block SHALL drive memory_enable=1, memory_wr=0 and memory_address = miss base + iss_cnt*STEP, and iss_cnt SHALL increment, giving one read issued per cycle (pipelined).
REQ-013 In FILL, each memory_data_valid SHALL produce, in the same cycle, write_data_array=1, write_address = miss base + rcv_cnt*STEP and write_data = memory_data; rcv_cnt SHALL then increment.
REQ-014 The valid that brings rcv_cnt to LINE_WORDS SHALL move the block to DONE.
REQ-015 DONE SHALL last exactly one cycle with write_tag_array=1, fill_done=1 and write_address = miss base, then return to IDLE.
REQ-016 fsm_busy SHALL be 1 whenever state != IDLE, and also in IDLE when miss_detected=1.
REQ-017 memory_data_valid SHALL be ignored outside FILL: no cache write and no counter change.
REQ-018 When a FILL response and a read issue happen in the same cycle, both counters SHALL update independently.
REQ-019 Dropping miss_detected after acceptance SHALL NOT abort the operation, and miss_address changes after acceptance SHALL be ignored.
REQ-020 Address arithmetic SHALL use only the OFF_W offset field; line-base bits SHALL never change.
REQ-021 Outputs not listed as active for the current state SHALL be 0.

Reset
REQ-022 With rst=1 at a clock edge, the next cycle SHALL have state=IDLE, all counters 0, latched addresses 0, and every output 0.
REQ-023 Reset asserted mid-WB or mid-FILL SHALL abandon the operation with no tag write and no fill_done; the next miss SHALL restart at word 0.

Structure
REQ-024 A shared package SHALL hold the state encoding constants and the default values for ADDR_W, DATA_W and LINE_WORDS.
REQ-025 A single sub-module, fill_counter (parametrised width, synchronous clear and increment), SHALL implement wb_cnt, iss_cnt and rcv_cnt.

Verification
REQ-026 Defaults, memory read latency 4: clean miss at 0x1234 SHALL give reads to 0x1230..0x123E on 8 consecutive cycles, data writes to 0x1230..0x123E on valids, write_tag_array and fill_done in the cycle after the last valid, then fsm_busy=0.
REQ-027 Dirty miss at 0x1234 with victim 0x5670 SHALL give 8 writes to 0x5670..0x567E carrying victim_data, then the reads of REQ-026.
REQ-028 WB_EN=0 with victim_dirty=1 SHALL give no memory writes and go straight to FILL.
REQ-029 Dropping miss_detected 2 cycles after acceptance SHALL still complete all 8 cache writes and the tag write.
REQ-030 rst after 3 responses SHALL give all outputs 0 next cycle and no write_tag_array; a new miss at 0x2000 SHALL then read 0x2000 first.
REQ-031 memory_data_valid pulsed in IDLE SHALL cause no cache write; with LINE_WORDS=4, a miss at 0x00F9 SHALL read 0x00F8, 0x00FA, 0x00FC and 0x00FE.
